// File: rtl/led_frame_buffer.sv
// led_frame_buffer: double-buffered 8x8 bitmap store for the LED row scanner.
// The CPU draws into the back bank; a commit swaps banks only on the scanner's
// frame boundary so a half-drawn image is never shown. A clear blanks the back
// bank over 8 cycles.
//
// Command protocol: wr_en, clear and commit are single-cycle strobes that are
// taken only in a cycle where busy is low (IDLE). While busy is high they are
// dropped, never queued. Priority in IDLE: clear > commit, and clear also
// drops a coincident write. A write and a commit together both take effect.
module led_frame_buffer #(
   parameter logic [7:0] ROW_BASE    = 8'd1,
   parameter logic [7:0] CLEAR_VALUE = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       clear,
   input  logic       commit,
   output logic       busy,
   output logic       front_bank,
   input  logic [7:0] rd_addr,
   input  logic       frame_start,
   output logic [7:0] row,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CLEAR   = 2'd1,
      S_PENDING = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       front_q, front_d;
   logic [7:0] row_q, row_d;
   logic [7:0] mem_q [2][8];
   logic [7:0] mem_d [2][8];
   logic       back_bank;
   logic [7:0] rd_off;

   assign back_bank = ~front_q;
   // Offset wraps in 8 bits, so addresses below ROW_BASE land far out of range.
   assign rd_off    = rd_addr - ROW_BASE;

   // State register: FSM, clear counter, bank select, read pipeline and storage.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         front_q <= 1'b0;
         row_q   <= 8'h00;
         for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < 8; r++) begin
               mem_q[b][r] <= 8'h00;
            end
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         front_q <= front_d;
         row_q   <= row_d;
         for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < 8; r++) begin
               mem_q[b][r] <= mem_d[b][r];
            end
         end
      end
   end

   // Next-state logic: command acceptance, clear sweep and frame-aligned swap.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      front_d = front_q;
      case (state_q)
         S_IDLE: begin
            if (clear) begin
               state_d = S_CLEAR;
               cnt_d   = 3'd0;
            end else if (commit) begin
               state_d = S_PENDING;
            end
         end
         S_CLEAR: begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = S_IDLE;
            end
         end
         S_PENDING: begin
            if (frame_start) begin
               front_d = ~front_q;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output logic: busy flag and externally visible state.
   always_comb begin
      busy      = (state_q != S_IDLE);
      state_dbg = state_q;
   end

   // Datapath: back-bank writes/clears and the registered front-bank read.
   always_comb begin
      mem_d = mem_q;
      if (state_q == S_IDLE && wr_en && !clear) begin
         mem_d[back_bank][wr_addr] = wr_data;
      end else if (state_q == S_CLEAR) begin
         mem_d[back_bank][cnt_q] = CLEAR_VALUE;
      end
      // Read uses the pre-swap bank; a swap on this edge shows from the next read.
      row_d = 8'h00;
      if (rd_off < 8'd8) begin
         row_d = mem_q[front_q][rd_off[2:0]];
      end
   end

   assign front_bank = front_q;
   assign row        = row_q;

endmodule

// File: tb/tb_led_frame_buffer.sv
// tb_led_frame_buffer: directed scenarios plus randomized traffic, each cycle
// compared against a behavioural model of the double-buffered frame store.
module tb_led_frame_buffer;

   localparam logic [7:0] ROW_BASE    = 8'd1;
   localparam logic [7:0] CLEAR_VALUE = 8'hFF;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic       clear;
   logic       commit;
   logic       busy;
   logic       front_bank;
   logic [7:0] rd_addr;
   logic       frame_start;
   logic [7:0] row;
   logic [1:0] state_dbg;

   always #5 clk = ~clk;

   led_frame_buffer #(
      .ROW_BASE    (ROW_BASE),
      .CLEAR_VALUE (CLEAR_VALUE)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .clear       (clear),
      .commit      (commit),
      .busy        (busy),
      .front_bank  (front_bank),
      .rd_addr     (rd_addr),
      .frame_start (frame_start),
      .row         (row),
      .state_dbg   (state_dbg)
   );

   // ---------------- scoreboard / model ----------------
   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] m_mem [2][8];
   int         m_front;
   int         m_clear_left;
   bit         m_pending;
   logic [7:0] m_row;
   logic [7:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock of the frame-store behaviour, evaluated from the current inputs.
   task automatic model_step();
      int off;
      if (reset) begin
         for (int b = 0; b < 2; b++)
            for (int r = 0; r < 8; r++) m_mem[b][r] = 8'h00;
         m_front = 0; m_clear_left = 0; m_pending = 0; m_row = 8'h00;
         return;
      end
      off = (int'(rd_addr) - int'(ROW_BASE) + 256) % 256;
      m_row = (off < 8) ? m_mem[m_front][off] : 8'h00;
      if (m_clear_left > 0) begin
         m_mem[1 - m_front][8 - m_clear_left] = CLEAR_VALUE;
         m_clear_left--;
      end else if (m_pending) begin
         if (frame_start) begin
            m_front   = 1 - m_front;
            m_pending = 0;
         end
      end else if (clear) begin
         m_clear_left = 8;
      end else begin
         if (wr_en) m_mem[1 - m_front][wr_addr] = wr_data;
         if (commit) m_pending = 1;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      model_step();
      exp_q.push_back(m_row);
      @(posedge clk);
      #1;
      check("row", {24'd0, row}, {24'd0, exp_q.pop_front()});
      check("busy", {31'd0, busy}, (m_clear_left > 0 || m_pending) ? 32'd1 : 32'd0);
      check("front_bank", {31'd0, front_bank}, m_front);
   endtask

   task automatic idle_inputs();
      wr_en = 0; wr_addr = 0; wr_data = 0; clear = 0; commit = 0; frame_start = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      step();
      step();
      reset = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int busy_cnt;
      idle_inputs();
      rd_addr = 8'd1;
      do_reset();

      // Reset then read rows 1..8.
      check("rst_front", {31'd0, front_bank}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      for (int a = 1; a <= 8; a++) begin
         rd_addr = 8'(a);
         step();
         check("rst_row", {24'd0, row}, 32'h00);
      end

      // Write walking-one rows, commit, swap.
      for (int i = 0; i < 8; i++) begin
         wr_en = 1; wr_addr = 3'(i); wr_data = 8'(1 << i);
         step();
      end
      wr_en = 0;
      commit = 1; step(); commit = 0;
      rd_addr = 8'd3; step();
      check("pre_swap_row", {24'd0, row}, 32'h00);
      frame_start = 1; step(); frame_start = 0;
      check("swap_front", {31'd0, front_bank}, 32'd1);
      rd_addr = 8'd3; step();
      check("swap_row3", {24'd0, row}, 32'h04);

      // Boundary addressing.
      rd_addr = 8'd0;   step(); check("addr0", {24'd0, row}, 32'h00);
      rd_addr = 8'd9;   step(); check("addr9", {24'd0, row}, 32'h00);
      rd_addr = 8'd255; step(); check("addr255", {24'd0, row}, 32'h00);
      rd_addr = 8'd8;   step(); check("addr8", {24'd0, row}, 32'h80);

      // Clear lasts 8 busy cycles, writes inside it are ignored.
      busy_cnt = 0;
      clear = 1; step(); clear = 0;
      if (busy) busy_cnt++;
      for (int i = 0; i < 7; i++) begin
         wr_en = 1; wr_addr = 3'd2; wr_data = 8'h55;
         step();
         if (busy) busy_cnt++;
      end
      wr_en = 0;
      step();
      if (busy) busy_cnt++;
      check("clear_busy_cycles", busy_cnt, 32'd8);
      commit = 1; step(); commit = 0;
      frame_start = 1; step(); frame_start = 0;
      check("clear_front", {31'd0, front_bank}, 32'd0);
      for (int a = 1; a <= 8; a++) begin
         rd_addr = 8'(a);
         step();
         check("clear_row", {24'd0, row}, 32'hFF);
      end

      // Commit coincident with frame_start does not swap on that pulse.
      commit = 1; frame_start = 1; step(); commit = 0; frame_start = 0;
      step();
      check("same_edge_front", {31'd0, front_bank}, 32'd0);
      check("same_edge_busy", {31'd0, busy}, 32'd1);
      frame_start = 1; step(); frame_start = 0;
      check("late_swap_front", {31'd0, front_bank}, 32'd1);

      // Clear and commit together: only the clear runs.
      clear = 1; commit = 1; step(); clear = 0; commit = 0;
      for (int i = 0; i < 7; i++) begin
         frame_start = (i == 3);
         step();
      end
      frame_start = 0;
      step();
      check("clr_commit_busy", {31'd0, busy}, 32'd0);
      frame_start = 1; step(); frame_start = 0;
      check("clr_commit_front", {31'd0, front_bank}, 32'd1);

      // Reset while pending aborts the swap.
      commit = 1; step(); commit = 0;
      step();
      do_reset();
      check("rst_pend_front", {31'd0, front_bank}, 32'd0);
      check("rst_pend_busy", {31'd0, busy}, 32'd0);
      for (int a = 1; a <= 8; a++) begin
         rd_addr = 8'(a);
         step();
         check("rst_pend_row", {24'd0, row}, 32'h00);
      end

      // Randomized traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         reset       = ($urandom_range(0, 199) == 0);
         wr_en       = ($urandom_range(0, 1) == 1);
         wr_addr     = 3'($urandom_range(0, 7));
         wr_data     = 8'($urandom_range(0, 255));
         clear       = ($urandom_range(0, 29) == 0);
         commit      = ($urandom_range(0, 9) == 0);
         frame_start = ($urandom_range(0, 7) == 0);
         rd_addr     = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                   : 8'($urandom_range(0, 9));
         step();
      end
      idle_inputs();
      reset = 0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/led_frame_buffer.md
# led_frame_buffer

Double-buffered 8x8 bitmap store feeding the LED matrix row scanner. The CPU side writes one 8-bit row at a time into the back bank. The scanner side reads the front bank by row address with one-cycle latency. A commit request swaps the banks only at the scanner's frame boundary, so a partially drawn image is never displayed; a clear command blanks the back bank over 8 cycles.

## Interface
Parameters:
- ROW_BASE, 1: scanner address of the first row; `rd_addr` ROW_BASE..ROW_BASE+7 maps to rows 0..7.
- CLEAR_VALUE, 8'h00: pattern written to every back-bank row by a clear.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  write strobe for the back bank.
- wr_addr  in  3  back-bank row index, 0..7.
- wr_data  in  8  row bitmap; bit i = column i lit.
- clear  in  1  start a back-bank clear.
- commit  in  1  request a bank swap at the next frame boundary.
- busy  out  1  high while in CLEAR or PENDING.
- front_bank  out  1  index of the bank currently displayed.
- rd_addr  in  8  row address from the scanner counter.
- frame_start  in  1  one-cycle pulse from the scanner when it restarts at ROW_BASE.
- row  out  8  registered front-bank row data to the scanner.

## Operation
- Storage: two banks of 8 x 8-bit registers. The back bank is `~front_bank`.
- States:
  - IDLE: writes and commands are accepted.
  - CLEAR: a 3-bit counter c runs 0..7; each cycle writes CLEAR_VALUE to back[c].
  - PENDING: waiting for `frame_start`.
- Transitions:
  - IDLE + clear -> CLEAR, with c=0.
  - IDLE + commit (clear low) -> PENDING.
  - CLEAR with c==7 -> IDLE after that write completes.
  - PENDING + frame_start -> toggle `front_bank`, then IDLE.
- Writes: in IDLE, wr_en && !clear writes `wr_data` to back[wr_addr].
- Simultaneous events:
  - wr_en and commit together in IDLE: the write lands, then the block enters PENDING.
  - clear and commit together in IDLE: clear wins and commit is dropped.
  - clear and wr_en together: the write is dropped.
- While busy, wr_en, clear and commit are ignored (no queuing).
- frame_start in IDLE or CLEAR has no effect.
- Read: row <= (rd_addr - ROW_BASE) in 0..7 ? front[rd_addr - ROW_BASE] : 8'h00.
  - The subtraction is done in 8-bit unsigned arithmetic, so rd_addr < ROW_BASE wraps to a large value and reads as 0.
- Reset:
  - Both banks cleared to 8'h00.
  - front_bank=0, row=8'h00, busy=0, state=IDLE, c=0.
  - Reset mid-CLEAR or mid-PENDING aborts the operation with no swap.

## Timing
- Read latency: 1 cycle. `row` at edge N+1 reflects `rd_addr` and `front_bank` sampled at edge N.
- Swap cycle: the edge that samples frame_start in PENDING toggles front_bank. The read at that same edge still uses the old bank; the new bank is visible from the next read.
- Swap latency: commit at edge N gives PENDING from N+1. The swap happens at the first frame_start sampled at edge >= N+1. A frame_start at the same edge as the commit is not used.
- busy rises at the edge after clear/commit is accepted and falls at the edge leaving CLEAR/PENDING.
- Clear duration: exactly 8 cycles in CLEAR.
- Write latency: a write is visible to the scanner only after the next swap. Writes never alter the front bank.

## Test plan
- Reset then read: rd_addr=1..8 -> row=8'h00 each, one cycle later. front_bank=0, busy=0.
- Write and swap: write rows 0..7 = 8'h01,02,04,...,80, then commit. Read before frame_start -> 00. Pulse frame_start -> front_bank=1, and rd_addr=3 then returns 8'h04 one cycle later.
- Boundary addressing with ROW_BASE=1: rd_addr=0, 9 and 255 -> row=8'h00; rd_addr=8 -> row 7 data.
- Clear with CLEAR_VALUE=8'hFF: issue clear -> busy high for exactly 8 cycles. A wr_en during those cycles is ignored. Commit plus frame_start -> every row reads 8'hFF.
- Simultaneous events:
  - commit and frame_start on the same edge -> no swap until the next frame_start.
  - clear and commit together -> only the clear runs (busy for 8 cycles) and front_bank is unchanged afterward.
- Reset in PENDING: commit, assert reset before frame_start -> front_bank=0, busy=0, and all rows read 8'h00.
